fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 141L CPU.
- Owns the program counter and drives the combinational instr_rom address (16-bit PC in, 10-bit instruction out).
- Registers each fetched word into a one-entry instruction buffer and hands it to decode over a valid/ready handshake.
- Handles branch redirects, start/halt control and stall back-pressure.

Parameters:
- PC_W, 16, program counter / ROM address width.
- INSTR_W, 10, instruction width.
- RESET_PC, 0, PC loaded on reset and on start.
- HALT_OPCODE, 10'h3FF, instruction encoding that halts fetch.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins or restarts fetch at RESET_PC.
- pc_out  out  PC_W  address to instr_rom.
- instr_in  in  INSTR_W  data from instr_rom (combinational from pc_out).
- instr_out  out  INSTR_W  buffered instruction to decode.
- instr_pc  out  PC_W  address of instr_out.
- instr_valid  out  1  instr_out holds a valid instruction.
- instr_ready  in  1  decode accepts instr_out this cycle.
- branch_taken  in  1  redirect request from execute.
- branch_target  in  PC_W  redirect address.
- halted  out  1  high in HALTED state.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, pc=RESET_PC, instr_out=0, instr_pc=0, instr_valid=0, halted=0.
  - Reset mid-run aborts immediately; the buffer is discarded.
- pc_out always equals the pc register.
- States:
  - IDLE: no fetch, pc frozen. start -> RUN, pc=RESET_PC.
  - RUN:
    - Buffer free means !instr_valid || instr_ready.
    - Buffer free: capture instr_in into instr_out, pc into instr_pc, set instr_valid=1, pc<=pc+1.
    - Buffer not free (stall): hold pc and the buffer unchanged.
    - Fetch latency: one cycle from pc_out to instr_valid.
    - Sustained throughput: one instruction per cycle while instr_ready=1.
  - Halt: a captured word equal to HALT_OPCODE is delivered normally, then state -> HALTED and pc stays at halt address +1.
  - HALTED:
    - halted=1, no further fetch.
    - instr_valid stays 1 until accepted, then clears.
    - branch_taken is ignored.
    - start -> RUN, pc=RESET_PC, instr_valid=0.
- Branch (RUN):
  - branch_taken=1 sets pc<=branch_target and instr_valid<=0 (flush).
  - No capture that cycle, regardless of instr_ready or a HALT_OPCODE on instr_in.
  - The first target instruction is valid on the following cycle.
- Priority: reset > start > branch_taken > capture/halt > hold.
  - start while in RUN restarts: pc=RESET_PC, buffer flushed.
- pc increment wraps modulo 2^PC_W: 16'hFFFF -> 16'h0000, no flag.
- instr_out and instr_pc are stable while instr_valid=1 && instr_ready=0.

Optional Feature:
- Macro FETCH_CTRL_PERF_EN.
- Defined:
  - Adds 32-bit outputs fetch_count and stall_count, both reset to 0 and cleared on start.
  - fetch_count increments on each capture.
  - stall_count increments on each RUN cycle with instr_valid=1 && instr_ready=0 && !branch_taken.
  - Both counters saturate at 32'hFFFF_FFFF.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package cpu_pkg holds:
  - PC_W and INSTR_W constants.
  - HALT_OPCODE.
  - the fetch state typedef {IDLE, RUN, HALTED}.
- One natural sub-module: fetch_buf, the one-entry valid/ready holding register for instr_out/instr_pc.
- The PC and FSM stay in fetch_ctrl.

Test Plan:
- Reset then start, ROM 0..4 = {A,B,C,D,E}, instr_ready=1 -> instr_valid from cycle 2; instr_out A,B,C,D,E with instr_pc 0..4 on consecutive cycles.
- instr_ready=0 for 3 cycles while instr_out=B (pc=2) -> pc_out stays 2 and instr_out stays B; after ready returns, C follows next cycle.
- branch_taken with branch_target=16'h0040 while instr_pc=3 is buffered -> next cycle instr_valid=0, pc_out=0x40; then instr_pc=0x40.
- ROM[5]=10'h3FF -> 10'h3FF delivered with instr_pc=5, halted=1, pc_out stays 6; a branch while halted is ignored; start -> pc_out=0, halted=0.
- Branch to 16'hFFFF -> fetches 0xFFFF, then pc_out wraps to 0x0000.
- reset_n asserted mid-RUN with instr_valid=1 -> instr_valid and pc_out drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the 141L CPU front end.
//   PC_W        - program counter / instruction ROM address width
//   INSTR_W     - instruction word width
//   HALT_OPCODE - instruction encoding that stops fetch
//   fetch_state_t - fetch sequencer states
package cpu_pkg;

   localparam int PC_W    = 16;
   localparam int INSTR_W = 10;

   localparam logic [INSTR_W-1:0] HALT_OPCODE = 10'h3FF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// One-entry valid/ready holding register between fetch and decode.
// Ports:
//   clock, reset_n        - clock, async active-low reset
//   flush                 - drop the held word (wins over load)
//   load, load_instr/pc   - capture a new word and mark it valid
//   instr_ready           - decode accepts the held word this cycle
//   instr_out/pc/valid    - held word, its address, valid flag
//   buf_free              - a new word may be loaded this cycle
module fetch_buf
   import cpu_pkg::*;
(
   input  logic               clock,
   input  logic               reset_n,
   input  logic               flush,
   input  logic               load,
   input  logic [INSTR_W-1:0] load_instr,
   input  logic [PC_W-1:0]    load_pc,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr_out,
   output logic [PC_W-1:0]    instr_pc,
   output logic               instr_valid,
   output logic               buf_free
);

   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic               valid_q, valid_d;

   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         instr_d = load_instr;
         pc_d    = load_pc;
         valid_d = 1'b1;
      end else if (valid_q && instr_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         instr_q <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign instr_out   = instr_q;
   assign instr_pc    = pc_q;
   assign instr_valid = valid_q;
   assign buf_free    = !valid_q || instr_ready;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the combinational
// instruction ROM and hands fetched words to decode via fetch_buf.
// Ports:
//   clock, reset_n          - clock, async active-low reset
//   start                   - pulse: (re)start fetch at RESET_PC
//   pc_out / instr_in       - ROM address / ROM data
//   instr_out/pc/valid      - buffered word to decode
//   instr_ready             - decode accepts the buffered word
//   branch_taken/target     - redirect from execute
//   halted                  - fetch stopped on HALT_OPCODE
// Build option FETCH_CTRL_PERF_EN adds saturating 32-bit fetch_count and
// stall_count outputs, cleared on reset and on start.
//
// state  | meaning
// IDLE   | out of reset, nothing fetched, waiting for start
// RUN    | fetching one word per cycle whenever the buffer is free
// HALTED | halt word captured, draining buffer, waiting for start
module fetch_ctrl
   import cpu_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = '0
)(
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   output logic [PC_W-1:0]    pc_out,
   input  logic [INSTR_W-1:0] instr_in,
   output logic [INSTR_W-1:0] instr_out,
   output logic [PC_W-1:0]    instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   output logic               halted
`ifdef FETCH_CTRL_PERF_EN
   ,
   output logic [31:0]        fetch_count,
   output logic [31:0]        stall_count
`endif
);

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            halted_q, halted_d;
   logic            flush, load, buf_free;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      halted_d = halted_q;
      flush    = 1'b0;
      load     = 1'b0;
      if (start) begin
         state_d  = RUN;
         pc_d     = RESET_PC;
         halted_d = 1'b0;
         flush    = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               // A redirect squashes whatever the ROM returns this cycle,
               // including a halt word on the wrong path.
               if (branch_taken) begin
                  pc_d  = branch_target;
                  flush = 1'b1;
               end else if (buf_free) begin
                  load = 1'b1;
                  pc_d = pc_q + PC_W'(1);
                  if (instr_in == HALT_OPCODE) begin
                     state_d  = HALTED;
                     halted_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         halted_q <= halted_d;
      end
   end

   fetch_buf u_fetch_buf (
      .clock       (clock),
      .reset_n     (reset_n),
      .flush       (flush),
      .load        (load),
      .load_instr  (instr_in),
      .load_pc     (pc_q),
      .instr_ready (instr_ready),
      .instr_out   (instr_out),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .buf_free    (buf_free)
   );

   assign pc_out = pc_q;
   assign halted = halted_q;

`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] stall_count_q, stall_count_d;
   logic        stall_cycle;

   assign stall_cycle = (state_q == RUN) && instr_valid && !instr_ready && !branch_taken;

   always_comb begin
      fetch_count_d = fetch_count_q;
      stall_count_d = stall_count_q;
      if (start) begin
         fetch_count_d = '0;
         stall_count_d = '0;
      end else begin
         if (load && (fetch_count_q != '1))
            fetch_count_d = fetch_count_q + 32'd1;
         if (stall_cycle && (stall_count_q != '1))
            stall_count_d = stall_count_q + 32'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fetch_count_q <= '0;
         stall_count_q <= '0;
      end else begin
         fetch_count_q <= fetch_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign fetch_count = fetch_count_q;
   assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by a randomized run,
// all checked against a transaction-level model of the fetch rules.
module tb_fetch_ctrl;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic [15:0] pc_out;
   logic [9:0]  instr_in;
   logic [9:0]  instr_out;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic        halted;
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   int vectors = 0;
   int miscompares = 0;

   logic [9:0] rom [0:65535];
   assign instr_in = rom[pc_out];

   always #5 clock = ~clock;

   fetch_ctrl dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .start         (start),
      .pc_out        (pc_out),
      .instr_in      (instr_in),
      .instr_out     (instr_out),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .halted        (halted)
`ifdef FETCH_CTRL_PERF_EN
      ,
      .fetch_count   (fetch_count),
      .stall_count   (stall_count)
`endif
   );

   // Reference model: 0 = idle, 1 = running, 2 = halted
   int          m_mode;
   logic [15:0] m_pc;
   logic [15:0] m_ipc;
   logic [9:0]  m_out;
   logic        m_valid;
   longint      m_fetch;
   longint      m_stall;

   task automatic model_reset();
      m_mode  = 0;
      m_pc    = 16'h0000;
      m_ipc   = 16'h0000;
      m_out   = 10'h000;
      m_valid = 1'b0;
      m_fetch = 0;
      m_stall = 0;
   endtask

   // Drive one cycle of inputs, advance the model, sample at edge + 1.
   task automatic tick(input logic s, input logic r, input logic b, input logic [15:0] t);
      start         = s;
      instr_ready   = r;
      branch_taken  = b;
      branch_target = t;
      if (s) begin
         m_mode  = 1;
         m_pc    = 16'h0000;
         m_valid = 1'b0;
         m_fetch = 0;
         m_stall = 0;
      end else if (m_mode == 1) begin
         if (m_valid && !r && !b) m_stall++;
         if (b) begin
            m_pc    = t;
            m_valid = 1'b0;
         end else if (!m_valid || r) begin
            m_out   = rom[m_pc];
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 16'd1;
            m_fetch++;
            if (m_out == 10'h3FF) m_mode = 2;
         end
      end else if (m_mode == 2) begin
         if (m_valid && r) m_valid = 1'b0;
      end
      @(posedge clock);
      #1;
      start        = 1'b0;
      branch_taken = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
      model_reset();
      #12;
      vectors++;
      if (pc_out !== 16'h0000) begin miscompares++; $display("FAIL reset_pc: got %h want 0000", pc_out); end
      vectors++;
      if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
      vectors++;
      if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", halted); end
      vectors++;
      if (instr_out !== 10'h000 || instr_pc !== 16'h0000) begin
         miscompares++; $display("FAIL reset_buf: got %h/%h want 000/0000", instr_out, instr_pc);
      end
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      vectors++;
      if (pc_out !== 16'h0000 || instr_valid !== 1'b0) begin
         miscompares++; $display("FAIL idle_no_fetch: got pc %h valid %b want 0000 0", pc_out, instr_valid);
      end
   endtask

   task automatic test_stream();
      logic [9:0] exp [5];
      exp[0] = 10'h0A1; exp[1] = 10'h0B2; exp[2] = 10'h0C3; exp[3] = 10'h0D4; exp[4] = 10'h0E5;
      tick(1'b1, 1'b1, 1'b0, 16'h0);
      vectors++;
      if (pc_out !== 16'h0000 || instr_valid !== 1'b0) begin
         miscompares++; $display("FAIL start_first_cycle: got pc %h valid %b want 0000 0", pc_out, instr_valid);
      end
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 1'b1, 1'b0, 16'h0);
         vectors++;
         if (instr_valid !== 1'b1 || instr_out !== exp[i] || instr_pc !== 16'(i) || pc_out !== 16'(i + 1)) begin
            miscompares++;
            $display("FAIL stream_%0d: got v%b %h @%h pc %h want v1 %h @%h pc %h",
                     i, instr_valid, instr_out, instr_pc, pc_out, exp[i], 16'(i), 16'(i + 1));
         end
      end
   endtask

   task automatic test_halt();
      tick(1'b0, 1'b1, 1'b0, 16'h0);
      vectors++;
      if (instr_out !== 10'h3FF || instr_pc !== 16'h0005 || halted !== 1'b1 || pc_out !== 16'h0006) begin
         miscompares++;
         $display("FAIL halt_deliver: got %h @%h halted %b pc %h want 3ff @0005 1 0006", instr_out, instr_pc, halted, pc_out);
      end
      for (int i = 0; i < 2; i++) begin
         tick(1'b0, 1'b0, 1'b0, 16'h0);
         vectors++;
         if (instr_valid !== 1'b1 || pc_out !== 16'h0006) begin
            miscompares++; $display("FAIL halt_hold: got v%b pc %h want v1 pc 0006", instr_valid, pc_out);
         end
      end
      tick(1'b0, 1'b0, 1'b1, 16'h0040);
      vectors++;
      if (pc_out !== 16'h0006 || halted !== 1'b1 || instr_valid !== 1'b1) begin
         miscompares++; $display("FAIL halt_branch_ignored: got pc %h halted %b v%b want 0006 1 1", pc_out, halted, instr_valid);
      end
      tick(1'b0, 1'b1, 1'b0, 16'h0);
      vectors++;
      if (instr_valid !== 1'b0 || halted !== 1'b1 || pc_out !== 16'h0006) begin
         miscompares++; $display("FAIL halt_drain: got v%b halted %b pc %h want 0 1 0006", instr_valid, halted, pc_out);
      end
      tick(1'b1, 1'b0, 1'b0, 16'h0);
      vectors++;
      if (pc_out !== 16'h0000 || halted !== 1'b0 || instr_valid !== 1'b0) begin
         miscompares++; $display("FAIL halt_restart: got pc %h halted %b v%b want 0000 0 0", pc_out, halted, instr_valid);
      end
   endtask

   task automatic test_stall();
      tick(1'b0, 1'b1, 1'b0, 16'h0);
      tick(1'b0, 1'b1, 1'b0, 16'h0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0, 1'b0, 16'h0);
         vectors++;
         if (pc_out !== 16'h0002 || instr_out !== 10'h0B2 || instr_pc !== 16'h0001 || instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_%0d: got pc %h %h @%h v%b want 0002 0b2 @0001 v1", i, pc_out, instr_out, instr_pc, instr_valid);
         end
      end
      tick(1'b0, 1'b1, 1'b0, 16'h0);
      vectors++;
      if (instr_out !== 10'h0C3 || instr_pc !== 16'h0002 || pc_out !== 16'h0003) begin
         miscompares++; $display("FAIL stall_resume: got %h @%h pc %h want 0c3 @0002 0003", instr_out, instr_pc, pc_out);
      end
   endtask

   task automatic test_branch();
      tick(1'b0, 1'b1, 1'b0, 16'h0);
      tick(1'b0, 1'b1, 1'b1, 16'h0040);
      vectors++;
      if (instr_valid !== 1'b0 || pc_out !== 16'h0040) begin
         miscompares++; $display("FAIL branch_flush: got v%b pc %h want 0 0040", instr_valid, pc_out);
      end
      tick(1'b0, 1'b1, 1'b0, 16'h0);
      vectors++;
      if (instr_valid !== 1'b1 || instr_pc !== 16'h0040 || instr_out !== 10'h140) begin
         miscompares++; $display("FAIL branch_target: got v%b %h @%h want 1 140 @0040", instr_valid, instr_out, instr_pc);
      end
   endtask

   task automatic test_wrap();
      tick(1'b0, 1'b1, 1'b1, 16'hFFFF);
      vectors++;
      if (pc_out !== 16'hFFFF || instr_valid !== 1'b0) begin
         miscompares++; $display("FAIL wrap_branch: got pc %h v%b want ffff 0", pc_out, instr_valid);
      end
      tick(1'b0, 1'b1, 1'b0, 16'h0);
      vectors++;
      if (instr_pc !== 16'hFFFF || instr_out !== 10'h2EE || pc_out !== 16'h0000) begin
         miscompares++; $display("FAIL wrap_pc: got %h @%h pc %h want 2ee @ffff 0000", instr_out, instr_pc, pc_out);
      end
   endtask

   task automatic test_async_reset();
      #1;
      reset_n = 1'b0;
      #1;
      vectors++;
      if (instr_valid !== 1'b0 || pc_out !== 16'h0000 || halted !== 1'b0) begin
         miscompares++; $display("FAIL async_reset: got v%b pc %h halted %b want 0 0000 0", instr_valid, pc_out, halted);
      end
      model_reset();
      #5;
      reset_n = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_random();
      logic s, r, b;
      logic [15:0] t;
      for (int a = 0; a < 65536; a++) begin
         rom[a] = ($urandom_range(0, 15) == 0) ? 10'h3FF : 10'($urandom_range(0, 1022));
      end
      tick(1'b1, 1'b1, 1'b0, 16'h0);
      for (int n = 0; n < 3000; n++) begin
         s = ($urandom_range(0, 99) < 3);
         r = ($urandom_range(0, 99) < 70);
         b = ($urandom_range(0, 99) < 10);
         t = ($urandom_range(0, 9) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom_range(0, 255));
         tick(s, r, b, t);
         vectors++;
         if (pc_out !== m_pc) begin miscompares++; $display("FAIL rand_pc[%0d]: got %h want %h", n, pc_out, m_pc); end
         vectors++;
         if (instr_valid !== m_valid) begin miscompares++; $display("FAIL rand_valid[%0d]: got %b want %b", n, instr_valid, m_valid); end
         vectors++;
         if (halted !== (m_mode == 2)) begin miscompares++; $display("FAIL rand_halted[%0d]: got %b want %b", n, halted, m_mode == 2); end
         if (m_valid) begin
            vectors++;
            if (instr_out !== m_out || instr_pc !== m_ipc) begin
               miscompares++; $display("FAIL rand_buf[%0d]: got %h @%h want %h @%h", n, instr_out, instr_pc, m_out, m_ipc);
            end
         end
      end
`ifdef FETCH_CTRL_PERF_EN
      vectors++;
      if (fetch_count !== 32'(m_fetch) || stall_count !== 32'(m_stall)) begin
         miscompares++;
         $display("FAIL perf_counts: got %0d/%0d want %0d/%0d", fetch_count, stall_count, m_fetch, m_stall);
      end
`endif
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) rom[a] = 10'h000;
      rom[0] = 10'h0A1; rom[1] = 10'h0B2; rom[2] = 10'h0C3; rom[3] = 10'h0D4; rom[4] = 10'h0E5;
      rom[5] = 10'h3FF;
      rom[16'h0040] = 10'h140;
      rom[16'hFFFF] = 10'h2EE;
      test_reset();
      test_stream();
      test_halt();
      test_stall();
      test_branch();
      test_wrap();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
